conv_window_ctrl: RTL and testbench

- Sequencer for the two cascaded row_buffer line delays and the 3x3 window registers in the vision pipeline's convolution front end.
- Accepts a raster pixel stream framed by start/end-of-packet flags and tracks the pixel's x/y position.
- Drives a single shift enable into the row buffers and window registers, then issues a registered window-valid with the centre coordinates.
- Windows are issued only where the full 3x3 support lies inside the frame.

---
 rtl/conv_window_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv_window_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences the two row_buffer line delays and the 3x3 window
// registers of the convolution front end. It tracks the raster position of the
// incoming pixel stream, issues the shared shift enable, and presents a
// registered window-valid with the window centre coordinates.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_sop/in_eop upstream pixel beat and framing flags
//   in_ready              beat can be accepted (combinational)
//   shift_en              advance row buffers / window registers (combinational)
//   out_ready             downstream consumes the current window
//   win_valid             window registers hold a full 3x3 window
//   centre_x/centre_y     centre coordinates of that window
//   frame_done            one-cycle pulse after the last pixel of a frame
//   sync_err              one-cycle pulse on a framing violation
module conv_window_ctrl #(
  parameter  int unsigned IMAGE_WIDTH  = 640,
  parameter  int unsigned IMAGE_HEIGHT = 480,
  localparam int unsigned XW           = $clog2(IMAGE_WIDTH),
  localparam int unsigned YW           = $clog2(IMAGE_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  output logic          in_ready,
  output logic          shift_en,
  input  logic          out_ready,
  output logic          win_valid,
  output logic [XW-1:0] centre_x,
  output logic [YW-1:0] centre_y,
  output logic          frame_done,
  output logic          sync_err
);

  typedef enum logic {
    WAIT_SOP = 1'b0,
    ACTIVE   = 1'b1
  } state_e;

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          win_valid_q, win_valid_d;
  logic [XW-1:0] centre_x_q, centre_x_d;
  logic [YW-1:0] centre_y_q, centre_y_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_err_q, sync_err_d;

  logic          accept;
  logic          at_origin;
  logic          at_last;
  logic          has_support;

  // Single-stage output register: a new beat may enter whenever the held
  // window is empty or is being consumed this cycle.
  assign in_ready    = !win_valid_q || out_ready;
  assign accept      = in_valid && in_ready && !rst;
  assign at_origin   = (x_q == '0) && (y_q == '0);
  assign at_last     = (x_q == X_LAST) && (y_q == Y_LAST);
  assign has_support = (x_q >= XW'(2)) && (y_q >= YW'(2));

  // Next-state, window issue and framing checks
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    win_valid_d  = win_valid_q && !out_ready;
    centre_x_d   = centre_x_q;
    centre_y_d   = centre_y_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    shift_en     = 1'b0;

    unique case (state_q)
      WAIT_SOP: begin
        // Beats before a start-of-frame are dropped silently.
        if (accept && in_sop) begin
          shift_en = 1'b1;
          x_d      = XW'(1);
          y_d      = '0;
          state_d  = ACTIVE;
        end
      end

      ACTIVE: begin
        if (accept) begin
          shift_en = 1'b1;
          if (in_sop && !at_origin) begin
            // Restart: this beat becomes pixel (0,0) of a new frame.
            sync_err_d = 1'b1;
            x_d        = XW'(1);
            y_d        = '0;
          end else begin
            if (has_support) begin
              win_valid_d = 1'b1;
              centre_x_d  = x_q - XW'(1);
              centre_y_d  = y_q - YW'(1);
            end
            if (at_last) begin
              frame_done_d = 1'b1;
              sync_err_d   = !in_eop;
              x_d          = '0;
              y_d          = '0;
              state_d      = WAIT_SOP;
            end else if (in_eop) begin
              sync_err_d = 1'b1;
              x_d        = '0;
              y_d        = '0;
              state_d    = WAIT_SOP;
            end else if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end

      default: state_d = WAIT_SOP;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_SOP;
      x_q          <= '0;
      y_q          <= '0;
      win_valid_q  <= 1'b0;
      centre_x_q   <= '0;
      centre_y_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      win_valid_q  <= win_valid_d;
      centre_x_q   <= centre_x_d;
      centre_y_q   <= centre_y_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign centre_x   = centre_x_q;
  assign centre_y   = centre_y_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl with an 8x6 image. A frame-level
// reference model turns every accepted beat into expected windows and event
// pulses; a separate monitor consumes them as the DUT presents outputs.
module tb_conv_window_ctrl;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_sop, in_eop, out_ready;
  logic       in_ready, shift_en, win_valid, frame_done, sync_err;
  logic [2:0] centre_x;
  logic [2:0] centre_y;

  always #5 clk = ~clk;

  conv_window_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready), .shift_en(shift_en), .out_ready(out_ready),
    .win_valid(win_valid), .centre_x(centre_x), .centre_y(centre_y),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  typedef struct {
    int x;
    int y;
    int cyc;
  } win_t;

  win_t win_q[$];
  int   done_q[$];
  int   err_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit taken    = 1'b0;
  bit gaps     = 1'b0;
  int or_mode  = 0;

  // Reference model state: frame membership and raster index of next pixel.
  bit in_frame = 1'b0;
  int idx      = 0;

  int wins_seen = 0, shifts_seen = 0, dones_seen = 0, errs_seen = 0;
  int w0, s0, d0, e0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (sample %0d)", name, act, exp, cyc);
  endtask

  // Downstream readiness pattern
  always @(negedge clk) begin
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Reference model: runs on every accepted beat, pushes expectations
  always @(negedge clk) begin : model
    bit acc, es;
    int px, py;
    win_t w;
    #2;
    if (mon_en) begin
      acc = in_valid && in_ready;
      es  = 1'b0;
      if (rst) begin
        in_frame = 1'b0;
        idx      = 0;
      end else if (acc) begin
        taken = 1'b1;
        if (!in_frame) begin
          if (in_sop) begin
            es = 1'b1; in_frame = 1'b1; idx = 1;
          end
        end else begin
          es = 1'b1;
          if (in_sop) begin
            err_q.push_back(cyc + 1);
            idx = 1;
          end else begin
            px = idx % W;
            py = idx / W;
            if (px >= 2 && py >= 2) begin
              w.x = px - 1; w.y = py - 1; w.cyc = cyc + 1;
              win_q.push_back(w);
            end
            if (idx == W * H - 1) begin
              done_q.push_back(cyc + 1);
              if (!in_eop) err_q.push_back(cyc + 1);
              in_frame = 1'b0; idx = 0;
            end else if (in_eop) begin
              err_q.push_back(cyc + 1);
              in_frame = 1'b0; idx = 0;
            end else begin
              idx++;
            end
          end
        end
      end
      chk("shift_en", int'(shift_en), int'(es));
    end
  end

  // Monitor: compares presented outputs against the scoreboard queues
  always @(negedge clk) begin : monitor
    bit e, fresh;
    bit rst_prev  = 1'b0;
    bit held_prev = 1'b0;
    #3;
    if (mon_en) begin
      chk("in_ready", int'(in_ready), int'(!win_valid || out_ready));
      if (rst_prev) begin
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_centre_x", int'(centre_x), 0);
        chk("rst_centre_y", int'(centre_y), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_sync_err", int'(sync_err), 0);
      end
      e = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("frame_done", int'(frame_done), int'(e));
      if (e) void'(done_q.pop_front());
      e = (err_q.size() > 0) && (err_q[0] == cyc);
      chk("sync_err", int'(sync_err), int'(e));
      if (e) void'(err_q.pop_front());
      if (frame_done) dones_seen++;
      if (sync_err) errs_seen++;
      if (shift_en) shifts_seen++;

      fresh = !held_prev;
      if (win_valid) begin
        if (win_q.size() == 0) begin
          chk("win_unexpected", 1, 0);
        end else begin
          chk("centre_x", int'(centre_x), win_q[0].x);
          chk("centre_y", int'(centre_y), win_q[0].y);
          if (fresh) chk("win_latency", cyc, win_q[0].cyc);
          if (out_ready) begin
            void'(win_q.pop_front());
            wins_seen++;
          end
        end
      end else if (win_q.size() > 0 && win_q[0].cyc <= cyc) begin
        chk("win_missing", 0, 1);
        void'(win_q.pop_front());
      end
      held_prev = win_valid && !out_ready;
      rst_prev  = rst;
    end
    cyc++;
  end

  task automatic idle(input int n);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input bit sop, input bit eop);
    if (gaps) idle($urandom_range(0, 2));
    in_valid = 1'b1; in_sop = sop; in_eop = eop;
    taken = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (taken) break;
    end
    chk("beat_accepted", int'(taken), 1);
    taken = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send(input int n, input int sop_at, input int eop_at);
    for (int i = 0; i < n; i++) beat(i == sop_at, i == eop_at);
  endtask

  task automatic snap();
    w0 = wins_seen; s0 = shifts_seen; d0 = dones_seen; e0 = errs_seen;
  endtask

  task automatic phase_chk(input string nm, input int ew, input int es,
                           input int ed, input int ee);
    idle(6);
    chk({nm, "_windows"}, wins_seen - w0, ew);
    chk({nm, "_shifts"}, shifts_seen - s0, es);
    chk({nm, "_frame_done"}, dones_seen - d0, ed);
    chk({nm, "_sync_err"}, errs_seen - e0, ee);
    snap();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    snap();

    // Continuous frame
    send(48, 0, 47);
    phase_chk("stream", 24, 48, 1, 0);

    // Downstream toggling every cycle
    or_mode = 1;
    send(48, 0, 47);
    phase_chk("backpressure", 24, 48, 1, 0);
    or_mode = 0;

    // Garbage before start-of-frame
    send(5, -1, -1);
    send(48, 0, 47);
    phase_chk("pre_sop", 24, 48, 1, 0);

    // Early end-of-frame at (4,2), then a clean frame
    send(21, 0, 20);
    send(48, 0, 47);
    phase_chk("early_eop", 27, 69, 1, 1);

    // Start-of-frame reasserted on beat 30
    send(30, 0, -1);
    send(48, 0, 47);
    phase_chk("mid_sop", 34, 78, 1, 1);

    // Reset after beat 24, garbage, then a clean frame
    send(25, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(3, -1, -1);
    send(48, 0, 47);
    phase_chk("mid_reset", 30, 73, 1, 0);

    // Random gaps, random backpressure, occasional framing errors
    gaps = 1'b1;
    or_mode = 2;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 2) == 0) send($urandom_range(1, 4), -1, -1);
      for (int i = 0; i < 48; i++)
        beat((i == 0) ^ ($urandom_range(0, 49) == 0),
             (i == 47) ^ ($urandom_range(0, 49) == 0));
    end
    gaps = 1'b0;
    or_mode = 0;
    idle(10);

    chk("win_queue_empty", win_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
